// File: rtl/line_check_sched.sv
// Shares one external LineCheck across the six edges of a tetrahedron wireframe.
// Pending/active vertex banks commit on frame_start; each pixel yields a 6-bit on-line mask.
module line_check_sched #(
    parameter int unsigned W = 21
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start_i,
    input  logic                vtx_we_i,
    input  logic [1:0]          vtx_idx_i,
    input  logic signed [W-1:0] vtx_x_i,
    input  logic signed [W-1:0] vtx_y_i,
    input  logic [5:0]          edge_en_i,
    input  logic                pix_valid_i,
    output logic                pix_ready_o,
    input  logic signed [W-1:0] pix_h_i,
    input  logic signed [W-1:0] pix_v_i,
    output logic signed [W-1:0] line_h_o,
    output logic signed [W-1:0] line_v_o,
    output logic signed [W-1:0] line_ax_o,
    output logic signed [W-1:0] line_ay_o,
    output logic signed [W-1:0] line_bx_o,
    output logic signed [W-1:0] line_by_o,
    input  logic                line_on_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [5:0]          res_mask_o,
    output logic                res_any_o
);

    typedef enum logic [1:0] {StIdle, StEval, StResult} state_e;

    state_e              state_q;
    logic [2:0]          edge_idx_q;
    logic signed [W-1:0] pend_x_q [4];
    logic signed [W-1:0] pend_y_q [4];
    logic signed [W-1:0] pend_x_d [4];
    logic signed [W-1:0] pend_y_d [4];
    logic signed [W-1:0] act_x_q  [4];
    logic signed [W-1:0] act_y_q  [4];
    logic signed [W-1:0] pix_h_q;
    logic signed [W-1:0] pix_v_q;
    logic                commit_pend_q;
    logic                res_valid_q;
    logic [5:0]          mask_q;
    logic                do_commit;
    logic                accept;
    logic [1:0]          sel_a;
    logic [1:0]          sel_b;

    // Same-cycle write is folded in so a commit in that cycle captures it.
    always_comb begin
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        if (vtx_we_i) begin
            pend_x_d[vtx_idx_i] = vtx_x_i;
            pend_y_d[vtx_idx_i] = vtx_y_i;
        end
    end

    always_comb begin
        sel_a = 2'd0;
        sel_b = 2'd1;
        case (edge_idx_q)
            3'd0:    begin sel_a = 2'd0; sel_b = 2'd1; end
            3'd1:    begin sel_a = 2'd0; sel_b = 2'd2; end
            3'd2:    begin sel_a = 2'd0; sel_b = 2'd3; end
            3'd3:    begin sel_a = 2'd1; sel_b = 2'd2; end
            3'd4:    begin sel_a = 2'd1; sel_b = 2'd3; end
            3'd5:    begin sel_a = 2'd2; sel_b = 2'd3; end
            default: begin sel_a = 2'd0; sel_b = 2'd1; end
        endcase
    end

    assign do_commit   = (state_q == StIdle) && (commit_pend_q || frame_start_i);
    assign accept      = (state_q == StIdle) && pix_valid_i;
    assign pix_ready_o = (state_q == StIdle);
    assign line_h_o    = pix_h_q;
    assign line_v_o    = pix_v_q;
    assign line_ax_o   = act_x_q[sel_a];
    assign line_ay_o   = act_y_q[sel_a];
    assign line_bx_o   = act_x_q[sel_b];
    assign line_by_o   = act_y_q[sel_b];
    assign res_valid_o = res_valid_q;
    assign res_mask_o  = mask_q;
    assign res_any_o   = |mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            edge_idx_q    <= 3'd0;
            commit_pend_q <= 1'b0;
            res_valid_q   <= 1'b0;
            mask_q        <= 6'd0;
            pix_h_q       <= '0;
            pix_v_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                pend_x_q[i] <= '0;
                pend_y_q[i] <= '0;
                act_x_q[i]  <= '0;
                act_y_q[i]  <= '0;
            end
        end else begin
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
            if (do_commit) begin
                act_x_q       <= pend_x_d;
                act_y_q       <= pend_y_d;
                commit_pend_q <= 1'b0;
            end else if (frame_start_i) begin
                commit_pend_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        pix_h_q    <= pix_h_i;
                        pix_v_q    <= pix_v_i;
                        mask_q     <= 6'd0;
                        edge_idx_q <= 3'd0;
                        state_q    <= StEval;
                    end
                end
                StEval: begin
                    mask_q[edge_idx_q] <= line_on_i & edge_en_i[edge_idx_q];
                    if (edge_idx_q == 3'd5) begin
                        edge_idx_q  <= 3'd0;
                        res_valid_q <= 1'b1;
                        state_q     <= StResult;
                    end else begin
                        edge_idx_q <= edge_idx_q + 3'd1;
                    end
                end
                StResult: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
